// File: rtl/dmem_pkg.sv
// Shared helpers for the banked data memory: bank-select width and address field decode.
package dmem_pkg;

  function automatic int bank_sel_w(input int nbanks);
    return $clog2(nbanks);
  endfunction

  function automatic logic [63:0] bank_of(input logic [63:0] a, input int bank_aw, input int sel_w);
    return (a >> bank_aw) & ((64'd1 << sel_w) - 64'd1);
  endfunction

  function automatic logic [63:0] idx_of(input logic [63:0] a, input int bank_aw);
    return a & ((64'd1 << bank_aw) - 64'd1);
  endfunction

  // Address is in range when nothing is set above the bank-select field.
  function automatic logic in_range(input logic [63:0] a, input int top_bit);
    return (a >> top_bit) == 64'd0;
  endfunction

endpackage

// File: rtl/banked_dmem_pipe_if.sv
// Memory-stage request/result bundle for banked_dmem_pipe.
interface banked_dmem_pipe_if #(
  parameter int DATA_W = 64,
  parameter int ADDR_W = 32,
  parameter int SIDE_W = 108
);
  logic                  stall;
  logic                  in_valid;
  logic [SIDE_W-1:0]     side_in;
  logic [DATA_W/8-1:0]   wr_be;
  logic [ADDR_W-1:0]     wr_addr;
  logic [DATA_W-1:0]     wr_data;
  logic                  rd_en;
  logic [ADDR_W-1:0]     rd_addr;
  logic                  out_valid;
  logic [SIDE_W-1:0]     side_out;
  logic [DATA_W-1:0]     rd_data;
  logic                  addr_err;

  modport master (
    output stall, in_valid, side_in, wr_be, wr_addr, wr_data, rd_en, rd_addr,
    input  out_valid, side_out, rd_data, addr_err
  );
  modport slave (
    input  stall, in_valid, side_in, wr_be, wr_addr, wr_data, rd_en, rd_addr,
    output out_valid, side_out, rd_data, addr_err
  );
endinterface

// File: rtl/banked_dmem_pipe_bank_ram.sv
// Simple-dual-port byte-enable RAM bank with a read-enabled, 1-cycle registered read (read-first).
module bank_ram #(
  parameter int DATA_W = 64,
  parameter int AW     = 15
) (
  input  logic                clk_i,
  input  logic                we_i,
  input  logic [DATA_W/8-1:0] be_i,
  input  logic [AW-1:0]       waddr_i,
  input  logic [DATA_W-1:0]   wdata_i,
  input  logic                re_i,
  input  logic [AW-1:0]       raddr_i,
  output logic [DATA_W-1:0]   rdata_o
);
  localparam int NBYTES = DATA_W / 8;

  logic [DATA_W-1:0] mem [2**AW];
  logic [DATA_W-1:0] rdata_q;

  always_ff @(posedge clk_i) begin
    if (we_i)
      for (int i = 0; i < NBYTES; i++)
        if (be_i[i]) mem[waddr_i][i*8 +: 8] <= wdata_i[i*8 +: 8];
    if (re_i) rdata_q <= mem[raddr_i];
  end

  assign rdata_o = rdata_q;
endmodule

// File: rtl/banked_dmem_pipe.sv
// Banked memory-stage data RAM with RD_LAT-deep sideband pipeline aligned to read data.
// Optional feature: STORE_FWD_EN merges same-cycle write bytes into a colliding read.
module banked_dmem_pipe
  import dmem_pkg::*;
#(
  parameter int DATA_W  = 64,
  parameter int ADDR_W  = 32,
  parameter int BANK_AW = 15,
  parameter int NBANKS  = 8,
  parameter int RD_LAT  = 2,
  parameter int SIDE_W  = 108
) (
  input logic              clk,
  input logic              rst,
  banked_dmem_pipe_if.slave bus
);
  localparam int BANK_SEL_W = bank_sel_w(NBANKS);
  localparam int NBYTES     = DATA_W / 8;
  localparam int TOP_BIT    = BANK_AW + BANK_SEL_W;

  typedef struct packed {
    logic                  valid;
    logic                  rd;
    logic                  err;
    logic [BANK_SEL_W-1:0] bank;
    logic [SIDE_W-1:0]     side;
  } stage_t;

  logic                  acc, wr_any, wr_inr, rd_inr;
  logic [BANK_SEL_W-1:0] wr_bank, rd_bank;
  logic [BANK_AW-1:0]    wr_idx, rd_idx;

  assign acc     = bus.in_valid & ~bus.stall & ~rst;
  assign wr_any  = |bus.wr_be;
  assign wr_inr  = in_range(64'(bus.wr_addr), TOP_BIT);
  assign rd_inr  = in_range(64'(bus.rd_addr), TOP_BIT);
  assign wr_bank = BANK_SEL_W'(bank_of(64'(bus.wr_addr), BANK_AW, BANK_SEL_W));
  assign rd_bank = BANK_SEL_W'(bank_of(64'(bus.rd_addr), BANK_AW, BANK_SEL_W));
  assign wr_idx  = BANK_AW'(idx_of(64'(bus.wr_addr), BANK_AW));
  assign rd_idx  = BANK_AW'(idx_of(64'(bus.rd_addr), BANK_AW));

  logic [NBANKS-1:0][DATA_W-1:0] ram_rd;

  // Read enable follows ~stall so the bank read register holds with the pipeline.
  for (genvar b = 0; b < NBANKS; b++) begin : g_bank
    bank_ram #(.DATA_W(DATA_W), .AW(BANK_AW)) u_ram (
      .clk_i   (clk),
      .we_i    (acc & wr_any & wr_inr & (wr_bank == BANK_SEL_W'(b))),
      .be_i    (bus.wr_be),
      .waddr_i (wr_idx),
      .wdata_i (bus.wr_data),
      .re_i    (~bus.stall),
      .raddr_i (rd_idx),
      .rdata_o (ram_rd[b])
    );
  end

  stage_t stg_q [1:RD_LAT];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int k = 1; k <= RD_LAT; k++) stg_q[k] <= '0;
    end else if (!bus.stall) begin
      stg_q[1] <= '{valid: acc,
                    rd:    acc & bus.rd_en & rd_inr,
                    err:   acc & ((bus.rd_en & ~rd_inr) | (wr_any & ~wr_inr)),
                    bank:  rd_bank,
                    side:  bus.side_in};
      for (int k = 2; k <= RD_LAT; k++) stg_q[k] <= stg_q[k-1];
    end
  end

  logic [DATA_W-1:0] bank_sel, merged, rd_s1;
  assign bank_sel = ram_rd[stg_q[1].bank];

`ifdef STORE_FWD_EN
  logic                collide;
  logic                fwd_q;
  logic [NBYTES-1:0]   fwd_be_q;
  logic [DATA_W-1:0]   fwd_data_q;

  assign collide = acc & wr_any & wr_inr & bus.rd_en & rd_inr & (bus.wr_addr == bus.rd_addr);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      fwd_q      <= 1'b0;
      fwd_be_q   <= '0;
      fwd_data_q <= '0;
    end else if (!bus.stall) begin
      fwd_q      <= collide;
      fwd_be_q   <= bus.wr_be;
      fwd_data_q <= bus.wr_data;
    end
  end

  // RAM returned pre-write data; overlay the bytes the colliding write stored.
  always_comb begin
    merged = bank_sel;
    if (fwd_q)
      for (int i = 0; i < NBYTES; i++)
        if (fwd_be_q[i]) merged[i*8 +: 8] = fwd_data_q[i*8 +: 8];
  end
`else
  assign merged = bank_sel;
`endif

  assign rd_s1 = stg_q[1].rd ? merged : '0;

  if (RD_LAT == 1) begin : g_lat1
    assign bus.rd_data = rd_s1;
  end else begin : g_latn
    logic [DATA_W-1:0] dq [2:RD_LAT];
    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        for (int k = 2; k <= RD_LAT; k++) dq[k] <= '0;
      end else if (!bus.stall) begin
        dq[2] <= rd_s1;
        for (int k = 3; k <= RD_LAT; k++) dq[k] <= dq[k-1];
      end
    end
    assign bus.rd_data = dq[RD_LAT];
  end

  // An op is emitted in a non-stalled cycle, and that same edge replaces it: no duplicates.
  assign bus.out_valid = stg_q[RD_LAT].valid & ~bus.stall;
  assign bus.addr_err  = stg_q[RD_LAT].valid & stg_q[RD_LAT].err & ~bus.stall;
  assign bus.side_out  = stg_q[RD_LAT].side;
endmodule

// File: tb/tb_banked_dmem_pipe.sv
// Self-checking bench for banked_dmem_pipe: directed cases plus randomized traffic against a queue model.
module tb_banked_dmem_pipe;
  localparam int DATA_W = 64, ADDR_W = 32, BANK_AW = 15, NBANKS = 8, RD_LAT = 2, SIDE_W = 108;
  localparam int TOP_BIT = BANK_AW + $clog2(NBANKS);

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  banked_dmem_pipe_if #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .SIDE_W(SIDE_W)) bus ();

  banked_dmem_pipe #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .BANK_AW(BANK_AW), .NBANKS(NBANKS),
                     .RD_LAT(RD_LAT), .SIDE_W(SIDE_W)) dut (.clk(clk), .rst(rst), .bus(bus));

  typedef struct {
    logic [SIDE_W-1:0] side;
    logic [63:0]       data;
    bit                err;
    bit                known;
    int                rem;
  } exp_t;

  exp_t        exp_q [$];
  logic [63:0] mem [int unsigned];
  logic [63:0] got_data [int];
  bit          got_err [int];
  int          got_cyc [int];
  int          got_cnt [int];
  int          acc_cyc [int];
  logic [31:0] pool [16];
  int vectors = 0, miscompares = 0, cyc = 0;

  task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  function automatic int cnt_of(input int t);
    return got_cnt.exists(t) ? got_cnt[t] : 0;
  endfunction

  // Spec-level model: each accepted op yields one result after RD_LAT non-stalled cycles.
  task automatic model_accept();
    exp_t e;
    logic [31:0] wa, ra;
    bit winr, rinr, wany;
    logic [63:0] nv;
    wa = bus.wr_addr; ra = bus.rd_addr;
    winr = (wa >> TOP_BIT) == 0; rinr = (ra >> TOP_BIT) == 0;
    wany = |bus.wr_be;
    e.side = bus.side_in;
    e.err = (bus.rd_en && !rinr) || (wany && !winr);
    e.rem = RD_LAT;
    e.data = '0; e.known = 1'b1;
    if (bus.rd_en && rinr) begin
      e.known = mem.exists(ra);
      if (e.known) e.data = mem[ra];
`ifdef STORE_FWD_EN
      if (wany && winr && wa == ra)
        for (int i = 0; i < 8; i++) if (bus.wr_be[i]) e.data[i*8 +: 8] = bus.wr_data[i*8 +: 8];
`endif
    end
    exp_q.push_back(e);
    acc_cyc[int'(bus.side_in[31:0])] = cyc;
    if (wany && winr) begin
      nv = mem.exists(wa) ? mem[wa] : 64'h0;
      for (int i = 0; i < 8; i++) if (bus.wr_be[i]) nv[i*8 +: 8] = bus.wr_data[i*8 +: 8];
      mem[wa] = nv;
    end
  endtask

  always @(negedge clk) begin
    int t;
    if (rst) begin
      chk("reset_outs", {bus.out_valid, bus.addr_err, bus.rd_data, bus.side_out}, '0);
      exp_q.delete();
    end else begin
      if (bus.out_valid) begin
        t = int'(bus.side_out[31:0]);
        got_data[t] = bus.rd_data; got_err[t] = bus.addr_err;
        got_cyc[t] = cyc; got_cnt[t] = cnt_of(t) + 1;
      end
      if (!bus.stall) foreach (exp_q[i]) exp_q[i].rem = exp_q[i].rem - 1;
      if (exp_q.size() > 0 && exp_q[0].rem == 0) begin
        chk("out_valid", bus.out_valid, 1);
        chk("side_out", bus.side_out, exp_q[0].side);
        chk("addr_err", bus.addr_err, exp_q[0].err);
        if (exp_q[0].known) chk("rd_data", bus.rd_data, exp_q[0].data);
        void'(exp_q.pop_front());
      end else begin
        chk("no_spurious_valid", bus.out_valid, 0);
      end
      if (bus.in_valid && !bus.stall) model_accept();
    end
    cyc++;
  end

  task automatic step(input bit v, input bit st, input logic [7:0] be, input logic [31:0] wa,
                      input logic [63:0] wd, input bit re, input logic [31:0] ra, input int tag);
    logic [SIDE_W-1:0] s;
    s = SIDE_W'({$urandom, $urandom, $urandom, $urandom});
    s[31:0] = tag;
    bus.in_valid = v; bus.stall = st; bus.wr_be = be; bus.wr_addr = wa; bus.wr_data = wd;
    bus.rd_en = re; bus.rd_addr = ra; bus.side_in = s;
    @(posedge clk); #1;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(0, 0, 8'h0, 0, 0, 0, 0, 0);
  endtask

  function automatic logic [31:0] pick();
    if ($urandom_range(0, 9) == 0) return (32'h1 << $urandom_range(TOP_BIT, 31)) | 32'($urandom_range(0, 255));
    return pool[$urandom_range(0, 15)];
  endfunction

  initial begin
    logic [63:0] exp3;
    bit v, st, re;
    logic [7:0] be;
    logic [31:0] wa, ra;
    bus.in_valid = 0; bus.stall = 0; bus.wr_be = 0; bus.wr_addr = 0; bus.wr_data = 0;
    bus.rd_en = 0; bus.rd_addr = 0; bus.side_in = '0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    idle(2);

    // Write then read next cycle
    step(1, 0, 8'hFF, 32'h8, 64'h1122334455667788, 0, 0, 1);
    step(1, 0, 8'h00, 0, 0, 1, 32'h8, 2);
    idle(4);
    chk("t1_data", got_data[2], 64'h1122334455667788);
    chk("t1_latency", got_cyc[2] - acc_cyc[2], RD_LAT);

    // One write per bank, reads back in reverse order
    for (int b = 0; b < 8; b++) step(1, 0, 8'hFF, 32'(b) << 15, 64'(b), 0, 0, 10 + b);
    for (int k = 0; k < 8; k++) step(1, 0, 8'h00, 0, 0, 1, 32'(7 - k) << 15, 100 + k);
    idle(4);
    for (int k = 0; k < 8; k++) begin
      chk($sformatf("t2_data%0d", k), got_data[100 + k], 64'(7 - k));
      chk($sformatf("t2_order%0d", k), got_cyc[100 + k] - got_cyc[100], k);
    end

    // Same-cycle write + read collision
    step(1, 0, 8'hFF, 32'h10, 64'h0, 0, 0, 199);
    step(1, 0, 8'h0F, 32'h10, 64'hAAAA_AAAA_BBBB_BBBB, 1, 32'h10, 200);
    step(1, 0, 8'h00, 0, 0, 1, 32'h10, 201);
    idle(4);
`ifdef STORE_FWD_EN
    exp3 = 64'h0000_0000_BBBB_BBBB;
`else
    exp3 = 64'h0;
`endif
    chk("t3_collide", got_data[200], exp3);
    chk("t3_after", got_data[201], 64'h0000_0000_BBBB_BBBB);

    // Stall mid-stream
    step(1, 0, 8'h00, 0, 0, 1, 32'h8, 300);
    step(1, 0, 8'h00, 0, 0, 1, 32'h8000, 301);
    for (int i = 0; i < 3; i++) step(1, 1, 8'h00, 0, 0, 1, 32'h10000, 302);
    step(1, 0, 8'h00, 0, 0, 1, 32'h10000, 302);
    step(1, 0, 8'h00, 0, 0, 1, 32'h18000, 303);
    idle(4);
    chk("t4_d0", got_data[300], 64'h1122334455667788);
    chk("t4_d1", got_data[301], 64'h1);
    chk("t4_d2", got_data[302], 64'h2);
    chk("t4_d3", got_data[303], 64'h3);
    for (int k = 0; k < 4; k++) chk($sformatf("t4_once%0d", k), cnt_of(300 + k), 1);
    chk("t4_gap", got_cyc[303] - got_cyc[300], 3);

    // Out-of-range address
    step(1, 0, 8'hFF, 32'h40000, 64'hDEAD, 0, 0, 400);
    step(1, 0, 8'h00, 0, 0, 1, 32'h40000, 401);
    step(1, 0, 8'h00, 0, 0, 1, 32'h0, 402);
    idle(4);
    chk("t5_werr", got_err[400], 1);
    chk("t5_rerr", got_err[401], 1);
    chk("t5_rdata", got_data[401], 64'h0);
    chk("t5_bank0", got_data[402], 64'h0);
    chk("t5_ok", got_err[402], 0);

    // Reset with reads in flight
    step(1, 0, 8'h00, 0, 0, 1, 32'h8, 500);
    step(1, 0, 8'h00, 0, 0, 1, 32'h8000, 501);
    rst = 1'b1;
    #1 chk("t6_async", bus.out_valid, 0);
    idle(2);
    #1 rst = 1'b0;
    idle(6);
    chk("t6_drop0", cnt_of(500), 0);
    chk("t6_drop1", cnt_of(501), 0);

    // Randomized traffic over a pre-initialized address pool
    for (int i = 0; i < 16; i++) begin
      pool[i] = (32'(i % 8) << 15) | 32'((i * 37 + 5) & 32'h7FFF);
      step(1, 0, 8'hFF, pool[i], {32'(i), 32'hC0DE0000}, 0, 0, 900 + i);
    end
    for (int n = 0; n < 400; n++) begin
      v  = $urandom_range(0, 9) < 8;
      st = $urandom_range(0, 4) == 0;
      be = $urandom_range(0, 1) ? 8'($urandom) : 8'h0;
      wa = pick();
      ra = ($urandom_range(0, 3) == 0) ? wa : pick();
      re = $urandom_range(0, 9) < 7;
      step(v, st, be, wa, {$urandom, $urandom}, re, ra, 1000 + n);
    end
    idle(8);
    chk("drained", exp_q.size(), 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
